// File: rtl/riscv_divider_if.sv
// Divider handshake/data bundle between the EX-stage control (master) and
// the iterative divide/remainder unit (slave).
//   i_riscv_div_en        : divide/remainder instruction present in EX
//   i_riscv_div_ctrl      : funct3[1:0], [0]=unsigned, [1]=remainder
//   i_riscv_div_word      : W variant (32-bit op, sign-extended result)
//   i_riscv_div_rs1data   : dividend
//   i_riscv_div_rs2data   : divisor
//   i_riscv_div_globstall : global stall from the hazard unit
//   o_riscv_div_result    : quotient or remainder (registered)
//   o_riscv_div_valid     : result valid (registered)
interface riscv_divider_if #(
    parameter int unsigned XLEN = 64
);
    logic            i_riscv_div_en;
    logic [1:0]      i_riscv_div_ctrl;
    logic            i_riscv_div_word;
    logic [XLEN-1:0] i_riscv_div_rs1data;
    logic [XLEN-1:0] i_riscv_div_rs2data;
    logic            i_riscv_div_globstall;
    logic [XLEN-1:0] o_riscv_div_result;
    logic            o_riscv_div_valid;

    modport master (
        output i_riscv_div_en, i_riscv_div_ctrl, i_riscv_div_word,
               i_riscv_div_rs1data, i_riscv_div_rs2data, i_riscv_div_globstall,
        input  o_riscv_div_result, o_riscv_div_valid
    );

    modport slave (
        input  i_riscv_div_en, i_riscv_div_ctrl, i_riscv_div_word,
               i_riscv_div_rs1data, i_riscv_div_rs2data, i_riscv_div_globstall,
        output o_riscv_div_result, o_riscv_div_valid
    );
endinterface

// File: rtl/riscv_divider.sv
// Iterative RV64M divide/remainder unit (DIV/DIVU/REM/REMU and W variants).
// Restoring radix-2, one quotient bit per clock. Divide-by-zero and signed
// overflow complete in one edge; the result and valid are held in DONE
// until the pipeline advances (globstall low).
//   i_riscv_div_clk : clock, rising edge
//   i_riscv_div_rst : synchronous active-high reset
//   div_if          : slave side of the divider handshake/data bundle
module riscv_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic           i_riscv_div_clk,
    input  logic           i_riscv_div_rst,
    riscv_divider_if.slave div_if
);
    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CW   = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [1:0]      ctrl_q;
    logic            word_q;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] result_q;
    logic            valid_q;

    // Operand preparation and special-case detection (feeds registers only)
    logic [XLEN-1:0] op_a, op_b, a_mag, b_mag, min_val, spec_raw, spec_res;
    logic            is_signed, a_neg, b_neg, div_zero, ovf;

    always_comb begin
        op_a = div_if.i_riscv_div_rs1data;
        op_b = div_if.i_riscv_div_rs2data;
        if (div_if.i_riscv_div_word) begin
            if (div_if.i_riscv_div_ctrl[0]) begin
                op_a = {{HALF{1'b0}}, div_if.i_riscv_div_rs1data[HALF-1:0]};
                op_b = {{HALF{1'b0}}, div_if.i_riscv_div_rs2data[HALF-1:0]};
            end else begin
                op_a = {{HALF{div_if.i_riscv_div_rs1data[HALF-1]}}, div_if.i_riscv_div_rs1data[HALF-1:0]};
                op_b = {{HALF{div_if.i_riscv_div_rs2data[HALF-1]}}, div_if.i_riscv_div_rs2data[HALF-1:0]};
            end
        end
        is_signed = ~div_if.i_riscv_div_ctrl[0];
        a_neg     = is_signed & op_a[XLEN-1];
        b_neg     = is_signed & op_b[XLEN-1];
        a_mag     = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag     = b_neg ? (~op_b + 1'b1) : op_b;
        min_val   = div_if.i_riscv_div_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                            : {1'b1, {(XLEN-1){1'b0}}};
        div_zero  = (op_b == '0);
        ovf       = is_signed & (op_a == min_val) & (op_b == '1);
        if (div_zero)
            spec_raw = div_if.i_riscv_div_ctrl[1] ? op_a : '1;
        else
            spec_raw = div_if.i_riscv_div_ctrl[1] ? '0 : op_a;
        // W remainder of a zero divisor is the dividend sign-extended from bit 31, even for REMUW
        spec_res = div_if.i_riscv_div_word ? {{HALF{spec_raw[HALF-1]}}, spec_raw[HALF-1:0]} : spec_raw;
    end

    // One restoring step; shifted[XLEN] set implies the trial cannot borrow
    logic [XLEN:0]   shifted;
    logic            no_borrow;
    logic [XLEN-1:0] diff;

    always_comb begin
        shifted   = {rem, quo[XLEN-1]};
        no_borrow = (shifted >= {1'b0, dvs});
        diff      = shifted[XLEN-1:0] - dvs;
    end

    // Sign correction and width selection for the final result
    logic [XLEN-1:0] q_fix, r_fix, sel, fin;

    always_comb begin
        q_fix = neg_q ? (~quo + 1'b1) : quo;
        r_fix = neg_r ? (~rem + 1'b1) : rem;
        sel   = ctrl_q[1] ? r_fix : q_fix;
        fin   = word_q ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
    end

    always_ff @(posedge i_riscv_div_clk) begin
        if (i_riscv_div_rst) begin
            state    <= IDLE;
            ctrl_q   <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_if.i_riscv_div_en) begin
                        ctrl_q <= div_if.i_riscv_div_ctrl;
                        word_q <= div_if.i_riscv_div_word;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (div_zero || ovf) begin
                            result_q <= spec_res;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            rem <= '0;
                            // W dividends start in the upper half so 32 shifts leave the quotient in the low half
                            quo <= div_if.i_riscv_div_word ? (a_mag << HALF) : a_mag;
                            dvs <= b_mag;
                            cnt <= div_if.i_riscv_div_word ? CW'(HALF - 1) : CW'(XLEN - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= no_borrow ? diff : shifted[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], no_borrow};
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    result_q <= fin;
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (!div_if.i_riscv_div_globstall) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_if.o_riscv_div_result = result_q;
    assign div_if.o_riscv_div_valid  = valid_q;
endmodule

// File: tb/tb_riscv_divider.sv
// Self-checking bench for riscv_divider: directed vector table, stall and
// mid-operation reset sequences, and random operations against an
// arithmetic reference model.
module tb_riscv_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    riscv_divider_if #(.XLEN(64)) dif ();

    riscv_divider #(.XLEN(64)) dut (
        .i_riscv_div_clk (clk),
        .i_riscv_div_rst (rst),
        .div_if          (dif.slave)
    );

    typedef struct {
        logic [1:0]  ctrl;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_res;
        int unsigned exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: RISC-V M-extension semantics in plain arithmetic
    function automatic logic [63:0] ref_res(input logic [1:0] c, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0)
                r32 = c[1] ? a32 : 32'hFFFF_FFFF;
            else if (!c[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = c[1] ? 32'd0 : a32;
            else if (c[0])
                r32 = c[1] ? (a32 % b32) : (a32 / b32);
            else if (c[1])
                r32 = $signed(a32) % $signed(b32);
            else
                r32 = $signed(a32) / $signed(b32);
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0)
                r = c[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (!c[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r = c[1] ? 64'd0 : a;
            else if (c[0])
                r = c[1] ? (a % b) : (a / b);
            else if (c[1])
                r = $signed(a) % $signed(b);
            else
                r = $signed(a) / $signed(b);
        end
        return r;
    endfunction

    function automatic int unsigned ref_lat(input logic [1:0] c, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic special;
        if (w)
            special = (b[31:0] == 32'd0) ||
                      (!c[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else
            special = (b == 64'd0) ||
                      (!c[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
        return special ? 1 : (w ? 34 : 66);
    endfunction

    // Issue one op, scramble operands after accept, wait for valid, hold
    // globstall for stall_n cycles at completion, then let the pipeline advance.
    task automatic run_op(input logic [1:0] c, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int unsigned stall_n,
                          output logic [63:0] res, output int unsigned lat);
        dif.i_riscv_div_en        = 1'b1;
        dif.i_riscv_div_ctrl      = c;
        dif.i_riscv_div_word      = w;
        dif.i_riscv_div_rs1data   = a;
        dif.i_riscv_div_rs2data   = b;
        dif.i_riscv_div_globstall = 1'b0;
        @(posedge clk); #1;
        dif.i_riscv_div_rs1data   = {$urandom, $urandom};
        dif.i_riscv_div_rs2data   = {$urandom, $urandom};
        dif.i_riscv_div_globstall = 1'b1;
        lat = 1;
        while (!dif.o_riscv_div_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = dif.o_riscv_div_result;
        for (int unsigned i = 0; i < stall_n; i++) begin
            dif.i_riscv_div_globstall = 1'b1;
            @(posedge clk); #1;
            check("stall_valid", 64'(dif.o_riscv_div_valid), 64'd1);
            check("stall_hold", dif.o_riscv_div_result, res);
        end
        dif.i_riscv_div_globstall = 1'b0;
        dif.i_riscv_div_en        = 1'b0;
        @(posedge clk); #1;
        check("exit_valid", 64'(dif.o_riscv_div_valid), 64'd0);
    endtask

    initial begin
        vec_t vecs[13];
        logic [63:0] res;
        int unsigned lat;

        vecs[0]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
        vecs[1]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[2]  = '{2'b11, 1'b0, 64'd20, 64'd3, 64'd2, 66};
        vecs[3]  = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66};
        vecs[4]  = '{2'b01, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[5]  = '{2'b10, 1'b0, 64'd7, 64'd0, 64'd7, 1};
        vecs[6]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[7]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[8]  = '{2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        vecs[9]  = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[10] = '{2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        vecs[11] = '{2'b11, 1'b1, 64'hAAAA_AAAA_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 1};
        vecs[12] = '{2'b00, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 34};

        dif.i_riscv_div_en        = 1'b0;
        dif.i_riscv_div_ctrl      = 2'b00;
        dif.i_riscv_div_word      = 1'b0;
        dif.i_riscv_div_rs1data   = '0;
        dif.i_riscv_div_rs2data   = '0;
        dif.i_riscv_div_globstall = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(dif.o_riscv_div_valid), 64'd0);
        check("reset_result", dif.o_riscv_div_result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].ctrl, vecs[i].word, vecs[i].a, vecs[i].b, 0, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Completion under a 3-cycle stall, then a back-to-back op
        run_op(2'b00, 1'b0, 64'd100, 64'd7, 3, res, lat);
        check("stall_result", res, 64'd14);
        check("stall_latency", 64'(lat), 64'd66);
        run_op(2'b11, 1'b0, 64'd20, 64'd3, 0, res, lat);
        check("b2b_result", res, 64'd2);
        check("b2b_latency", 64'(lat), 64'd66);

        // Reset mid-CALC discards the op
        dif.i_riscv_div_en      = 1'b1;
        dif.i_riscv_div_ctrl    = 2'b00;
        dif.i_riscv_div_word    = 1'b0;
        dif.i_riscv_div_rs1data = 64'hFFFF_FFFF_FFFF_FFEC;
        dif.i_riscv_div_rs2data = 64'd3;
        @(posedge clk); #1;
        dif.i_riscv_div_en = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", 64'(dif.o_riscv_div_valid), 64'd0);
        check("midrst_result", dif.o_riscv_div_result, 64'd0);
        repeat (70) begin @(posedge clk); #1; end
        check("midrst_discard", 64'(dif.o_riscv_div_valid), 64'd0);
        run_op(2'b00, 1'b0, 64'd100, 64'd7, 0, res, lat);
        check("postrst_result", res, 64'd14);
        check("postrst_latency", 64'(lat), 64'd66);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  c;
            logic        w;
            logic [63:0] a, b;
            c = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
                2: b = 64'($urandom_range(1, 15));
                3: begin a = 64'($urandom); b = 64'($urandom_range(1, 1000)); end
                4: b = b >> $urandom_range(0, 63);
                default: ;
            endcase
            run_op(c, w, a, b, $urandom_range(0, 2), res, lat);
            check($sformatf("rnd%0d_result", i), res, ref_res(c, w, a, b));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(ref_lat(c, w, a, b)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
